rr_stream_mux: RTL

Parametrised, registered N:1 stream multiplexer with valid/ready handshakes and built-in arbitration, replacing the fixed 4:1 combinational select mux wherever several pipeline producers share one consumer (e.g. writeback sources, memory request ports). Selection is made by an internal round-robin or fixed-priority arbiter rather than an external select, and one output register stage breaks the timing path to the consumer.

---
 rtl/rr_stream_mux_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/rr_stream_mux.sv | 96 +++++++++
 3 files changed

// File: rtl/rr_stream_mux_pkg.sv
// Shared helpers for the rr_stream_mux block.
//   clog2 : ceiling log2, used to size channel-index fields from NUM_IN.
package rr_stream_mux_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: round-robin from a base pointer, or fixed priority.
//   i_req    : per-channel requests
//   i_base   : round-robin search start (must be < NUM_IN)
//   i_rr_en  : 1 = round-robin from i_base, 0 = lowest index wins
//   o_grant  : one-hot grant, zero when no request
//   o_idx    : encoded index of the granted channel (0 when none)
//   o_any    : a grant was issued
module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter int unsigned NUM_IN    = 4,
  localparam int unsigned SEL_WIDTH = clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0]    i_req,
  input  logic [SEL_WIDTH-1:0] i_base,
  input  logic                 i_rr_en,
  output logic [NUM_IN-1:0]    o_grant,
  output logic [SEL_WIDTH-1:0] o_idx,
  output logic                 o_any
);

  int unsigned          w_start;
  logic [SEL_WIDTH-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    // Fixed priority is simply a round-robin search anchored at channel 0.
    w_start = i_rr_en ? int'(i_base) : 0;
    for (int k = 0; k < int'(NUM_IN); k++) begin
      w_cand = SEL_WIDTH'((w_start + k) % NUM_IN);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// Registered N:1 valid/ready stream multiplexer with built-in arbitration.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_rr_en        : 1 = round-robin, 0 = fixed priority (lowest index)
//   i_in_valid     : per-channel valid
//   i_in_data      : flattened channel data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_in_ready     : per-channel ready, one-hot or zero
//   o_out_valid    : output register holds a beat
//   o_out_data     : data of the held beat
//   o_out_sel      : channel index that supplied the held beat
//   i_out_ready    : consumer accepts the held beat
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_IN     = 4,
  localparam int unsigned SEL_WIDTH  = clog2(NUM_IN)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_rr_en,
  input  logic [NUM_IN-1:0]            i_in_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0] i_in_data,
  output logic [NUM_IN-1:0]            o_in_ready,
  output logic                         o_out_valid,
  output logic [DATA_WIDTH-1:0]        o_out_data,
  output logic [SEL_WIDTH-1:0]         o_out_sel,
  input  logic                         i_out_ready
);

  logic [SEL_WIDTH-1:0]  r_ptr;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [SEL_WIDTH-1:0]  r_out_sel;

  logic [NUM_IN-1:0]     w_grant;
  logic [SEL_WIDTH-1:0]  w_idx;
  logic                  w_any;
  logic                  w_load;
  logic                  w_xfer;
  logic [SEL_WIDTH-1:0]  w_ptr_next;
  logic [DATA_WIDTH-1:0] w_sel_data;

  rr_arbiter #(
    .NUM_IN (NUM_IN)
  ) u_arbiter (
    .i_req   (i_in_valid),
    .i_base  (r_ptr),
    .i_rr_en (i_rr_en),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Register is free when empty or being drained this cycle.
  assign w_load     = ~r_out_valid | i_out_ready;
  assign o_in_ready = (w_load && !i_rst) ? w_grant : '0;
  assign w_xfer     = w_load & w_any & ~i_rst;

  // Explicit wrap keeps ptr below NUM_IN for non-power-of-two channel counts.
  assign w_ptr_next = (w_idx == SEL_WIDTH'(NUM_IN - 1)) ? '0 : w_idx + SEL_WIDTH'(1);

  // Grant is one-hot, so an OR-style select with constant slices suffices.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (w_grant[i]) begin
        w_sel_data = i_in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else begin
      if (w_load) begin
        r_out_valid <= w_any;
        if (w_any) begin
          r_out_data <= w_sel_data;
          r_out_sel  <= w_idx;
        end
      end
      if (w_xfer) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_sel   = r_out_sel;

endmodule
